// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for board-input conditioning blocks.
//   clog2()               : ceiling log2, usable in constant expressions.
//   DEBOUNCE_CYCLES_BOARD : default stability window for the board build.
package switch_debouncer_pkg;

    // 50 MHz clock x 10 ms settle time.
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 500000;

    // Returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer for a single asynchronous level.
// Ports:
//   clock  : destination clock
//   resetn : asynchronous active-low reset, clears both flops
//   d      : asynchronous input level
//   q      : synchronized level, two clock edges after d
module sync_2ff (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic sync0_q;

    // Nothing may sit between the two flops: the first one gets a full cycle to resolve.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync0_q <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync0_q <= d;
            q       <= sync0_q;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch/key input into a clean level synchronous to clock,
// with single-cycle rise/fall strobes.
// Parameters:
//   STABLE_CYCLES : consecutive synchronized samples that must disagree with
//                   clean_out before it changes (1 .. 2^20)
// Ports:
//   clock      : system clock, all state on posedge
//   resetn     : asynchronous active-low reset
//   noisy_in   : raw asynchronous switch level
//   clean_out  : debounced level (registered)
//   rise_pulse : one-cycle strobe in the first cycle clean_out reads 1 (registered)
//   fall_pulse : one-cycle strobe in the first cycle clean_out reads 0 (registered)
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic noisy_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CNT_WIDTH =
        (clog2(STABLE_CYCLES) > 1) ? clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync1;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clean_d, rise_d, fall_d;

    sync_2ff u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (noisy_in),
        .q      (sync1)
    );

    // Any sample agreeing with clean_out clears the count, so partial runs never accumulate.
    // The count saturates at CNT_LAST, where the output flips and the count restarts.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_out;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync1 != clean_out) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync1;
                rise_d  = sync1;
                fall_d  = ~sync1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            clean_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clean_out  <= clean_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: one instance with STABLE_CYCLES=4, one with 1.
module tb_switch_debouncer;

    logic clock;
    logic resetn_a, noisy_a, clean_a, rise_a, fall_a;
    logic resetn_b, noisy_b, clean_b, rise_b, fall_b;

    int n_checks = 0;
    int n_fail   = 0;

    switch_debouncer #(.STABLE_CYCLES(4)) dut_a (
        .clock      (clock),
        .resetn     (resetn_a),
        .noisy_in   (noisy_a),
        .clean_out  (clean_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a)
    );

    switch_debouncer #(.STABLE_CYCLES(1)) dut_b (
        .clock      (clock),
        .resetn     (resetn_b),
        .noisy_in   (noisy_b),
        .clean_out  (clean_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Step `edges` edges on instance sel (0=a, 1=b), counting pulses and noting the
    // 1-based edge index of the first of each (0 if none).
    task automatic window(input bit sel, input int edges,
                          output int n_rise, output int n_fall,
                          output int first_rise, output int first_fall,
                          output int n_both);
        logic r, f;
        n_rise = 0; n_fall = 0; first_rise = 0; first_fall = 0; n_both = 0;
        for (int i = 1; i <= edges; i++) begin
            @(posedge clock);
            #1;
            r = sel ? rise_b : rise_a;
            f = sel ? fall_b : fall_a;
            if (r) begin
                if (n_rise == 0) first_rise = i;
                n_rise++;
            end
            if (f) begin
                if (n_fall == 0) first_fall = i;
                n_fall++;
            end
            if (r && f) n_both++;
        end
    endtask

    int nr, nf, fr, ff, nb;

    initial begin
        resetn_a = 1'b0; noisy_a = 1'b0;
        resetn_b = 1'b0; noisy_b = 1'b0;

        // Reset held for 3 cycles with input low.
        step(3);
        check_eq("rst_clean_a", clean_a, 0);
        check_eq("rst_rise_a",  rise_a,  0);
        check_eq("rst_fall_a",  fall_a,  0);
        check_eq("rst_clean_b", clean_b, 0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;

        // Idle low: nothing happens.
        window(0, 8, nr, nf, fr, ff, nb);
        check_eq("idle_pulses", nr + nf, 0);
        check_eq("idle_clean", clean_a, 0);

        // Clean rise: visible after the 6th edge.
        noisy_a = 1'b1;
        window(0, 10, nr, nf, fr, ff, nb);
        check_eq("rise_count", nr, 1);
        check_eq("rise_edge", fr, 6);
        check_eq("rise_no_fall", nf, 0);
        check_eq("rise_clean", clean_a, 1);

        // Asynchronous reset mid-cycle while clean_out is high.
        #3;
        resetn_a = 1'b0;
        #1;
        check_eq("async_clean", clean_a, 0);
        check_eq("async_rise", rise_a, 0);
        check_eq("async_fall", fall_a, 0);
        step(1);
        resetn_a = 1'b1;

        // Release with input high: one rise after 6 edges.
        window(0, 10, nr, nf, fr, ff, nb);
        check_eq("relhi_rise_count", nr, 1);
        check_eq("relhi_rise_edge", fr, 6);
        check_eq("relhi_clean", clean_a, 1);

        // Clean fall from settled high.
        noisy_a = 1'b0;
        window(0, 10, nr, nf, fr, ff, nb);
        check_eq("fall_count", nf, 1);
        check_eq("fall_edge", ff, 6);
        check_eq("fall_no_rise", nr, 0);
        check_eq("fall_clean", clean_a, 0);

        // Two 3-cycle glitches: neither flips, and counts must not accumulate.
        for (int g = 0; g < 2; g++) begin
            noisy_a = 1'b1;
            step(3);
            noisy_a = 1'b0;
            window(0, 8, nr, nf, fr, ff, nb);
            check_eq("glitch_pulses", nr + nf, 0);
            check_eq("glitch_clean", clean_a, 0);
        end

        // Bounce train 1,0,1,1,0 then 1 held: one rise, 6 edges after the final 1.
        begin
            logic [4:0] bounce;
            int bounce_pulses;
            bounce = 5'b10110;
            bounce_pulses = 0;
            for (int i = 4; i >= 0; i--) begin
                noisy_a = bounce[i];
                window(0, 1, nr, nf, fr, ff, nb);
                bounce_pulses += nr + nf;
            end
            noisy_a = 1'b1;
            window(0, 10, nr, nf, fr, ff, nb);
            check_eq("bounce_early_pulses", bounce_pulses, 0);
            check_eq("bounce_rise_count", nr, 1);
            check_eq("bounce_rise_edge", fr, 6);
            check_eq("bounce_clean", clean_a, 1);
        end

        // Reset mid-count: bring output to 0, start a rise, reset once cnt is 2.
        resetn_a = 1'b0;
        noisy_a  = 1'b0;
        step(1);
        resetn_a = 1'b1;
        step(3);
        noisy_a = 1'b1;
        step(4);
        resetn_a = 1'b0;
        window(0, 2, nr, nf, fr, ff, nb);
        check_eq("midrst_pulses", nr + nf, 0);
        check_eq("midrst_clean", clean_a, 0);
        resetn_a = 1'b1;
        window(0, 10, nr, nf, fr, ff, nb);
        check_eq("midrst_rise_count", nr, 1);
        check_eq("midrst_rise_edge", fr, 6);

        // STABLE_CYCLES=1: 3-edge latency both ways, and after a reset.
        noisy_b = 1'b1;
        window(1, 6, nr, nf, fr, ff, nb);
        check_eq("b_rise_count", nr, 1);
        check_eq("b_rise_edge", fr, 3);
        check_eq("b_clean_hi", clean_b, 1);
        noisy_b = 1'b0;
        window(1, 6, nr, nf, fr, ff, nb);
        check_eq("b_fall_count", nf, 1);
        check_eq("b_fall_edge", ff, 3);
        check_eq("b_no_both", nb, 0);
        noisy_b = 1'b1;
        step(1);
        resetn_b = 1'b0;
        window(1, 2, nr, nf, fr, ff, nb);
        check_eq("b_rst_pulses", nr + nf, 0);
        check_eq("b_rst_clean", clean_b, 0);
        resetn_b = 1'b1;
        window(1, 6, nr, nf, fr, ff, nb);
        check_eq("b_relhi_rise_count", nr, 1);
        check_eq("b_relhi_rise_edge", fr, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
